// File: rtl/rv32_wb_interconnect_pkg.sv
// Shared types and constants for the RV32 data-port to Wishbone interconnect.
package rv32_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Read data returned to the core on any bus error.
    localparam logic [31:0] WB_ERR_DATA      = 32'h0000_0000;
    // Default peripheral region base.
    localparam logic [31:0] PERIPH_BASE_DFLT = 32'h8000_0000;

endpackage

// File: rtl/rv32_wb_interconnect_if.sv
// Shared Wishbone bus plus per-slave cyc/ack/data lanes.
// master: the interconnect; slave: the peripheral side (or a testbench).
interface rv32_wb_interconnect_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADR_W      = 16
);
    logic [NUM_SLAVES-1:0]       slv_cyc_o;
    logic [NUM_SLAVES-1:0]       slv_ack_i;
    logic [NUM_SLAVES-1:0][31:0] slv_dat_i;
    logic [ADR_W-1:0]            wb_adr_o;
    logic [31:0]                 wb_dat_o;
    logic                        wb_we_o;
    logic                        wb_stb_o;
    logic [3:0]                  wb_sel_o;

    modport master (
        output slv_cyc_o, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_sel_o,
        input  slv_ack_i, slv_dat_i
    );

    modport slave (
        input  slv_cyc_o, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_sel_o,
        output slv_ack_i, slv_dat_i
    );
endinterface

// File: rtl/rv32_wb_interconnect_watchdog.sv
// Bus-cycle watchdog: counts cycles from start_i until ack_i, raising
// timeout_o in the TIMEOUT_CYCLES-th cycle of the wait. The counter
// clears on start and saturates instead of wrapping.
module rv32_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    input  logic ack_i,
    output logic timeout_o
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             running;
    logic [CNT_W-1:0] cnt;

    // cnt holds (cycles waited - 1) while running
    assign timeout_o = running && (cnt >= LAST);

    // Arm on start, disarm on ack or expiry, count while armed
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start_i) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            if (ack_i || timeout_o) running <= 1'b0;
            if (cnt != LAST)        cnt     <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/rv32_wb_interconnect.sv
// RV32 data-memory port to N-slave Wishbone interconnect.
// Decodes the peripheral region, runs one access at a time on a shared
// bus with a one-hot per-slave cyc, and stalls the core until done.
// Optional feature macro: WB_TIMEOUT_EN compiles in the bus watchdog;
// without it BUS waits for the slave ack indefinitely.
module rv32_wb_interconnect
    import rv32_wb_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          ADR_W          = 16,
    parameter int          WIN_W          = 12,
    parameter logic [31:0] PERIPH_BASE    = PERIPH_BASE_DFLT,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  mem_we_i,
    input  logic        mem_re_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stall_o,
    output logic        mem_err_o,
    rv32_wb_interconnect_if.master wb
);

    wb_state_e state_q, state_d;

    logic [3:0]            idx_q;
    logic [ADR_W-1:0]      adr_q;
    logic [31:0]           dat_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q;

    logic                  hit, req, mapped;
    logic [3:0]            idx_in;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic                  ack_sel;
    logic [31:0]           dat_sel;
    logic                  timeout;
    logic                  latch, cap_rd, cap_err;

    assign hit    = (mem_addr_i[31:ADR_W] == PERIPH_BASE[31:ADR_W]);
    assign req    = hit && ((|mem_we_i) || mem_re_i);
    assign idx_in = mem_addr_i[WIN_W +: 4];
    assign mapped = (int'(idx_in) < NUM_SLAVES);

    // One-hot of the latched slave index and the matching ack/data lane
    always_comb begin
        sel_oh  = '0;
        dat_sel = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            sel_oh[s] = (idx_q == 4'(s));
            if (sel_oh[s]) dat_sel = wb.slv_dat_i[s];
        end
    end

    // Acks from slaves other than the selected one never count
    assign ack_sel = |(wb.slv_ack_i & sel_oh);

`ifdef WB_TIMEOUT_EN
    rv32_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (latch),
        .ack_i    ((state_q == BUS) && ack_sel),
        .timeout_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and datapath load strobes; ack has priority over timeout
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        latch   = 1'b0;
        cap_rd  = 1'b0;
        cap_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mapped) begin
                        state_d = BUS;
                        err_d   = 1'b0;
                        latch   = 1'b1;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        cap_err = 1'b1;
                    end
                end
            end
            BUS: begin
                if (ack_sel) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    cap_rd  = ~we_q;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    cap_err = 1'b1;
                end
            end
            // Always back to IDLE so the still-held request is not re-issued
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched request fields, error flag and read data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            err_q <= err_d;
            if (latch) begin
                idx_q <= idx_in;
                adr_q <= mem_addr_i[ADR_W-1:0];
                dat_q <= mem_data_i;
                we_q  <= |mem_we_i;
                sel_q <= (|mem_we_i) ? mem_we_i : 4'hF;
            end
            if (cap_rd)  rdata_q <= dat_sel;
            if (cap_err) rdata_q <= WB_ERR_DATA;
        end
    end

    // Stall is combinational from the request in IDLE; forced low in reset
    assign mem_stall_o  = rst_n_i && (((state_q == IDLE) && req) || (state_q == BUS));
    assign mem_err_o    = (state_q == RESP) && err_q;
    assign mem_data_o   = rdata_q;

    assign wb.slv_cyc_o = (state_q == BUS) ? sel_oh : '0;
    assign wb.wb_stb_o  = (state_q == BUS);
    assign wb.wb_adr_o  = adr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_sel_o  = sel_q;

endmodule

// File: tb/tb_rv32_wb_interconnect.sv
// Randomized self-checking bench for rv32_wb_interconnect. A
// transaction-level model predicts, per cycle, the outputs from the
// access type, target index and slave latency; a negedge compare process
// checks them, and directed accesses pin the model with literal values.
// Timeout scenarios are exercised when WB_TIMEOUT_EN is defined.
module tb_rv32_wb_interconnect;
    localparam int NS = 4;
    localparam int AW = 16;
    localparam int WW = 12;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, mem_err;

    always #5 clk = ~clk;

    rv32_wb_interconnect_if #(.NUM_SLAVES(NS), .ADR_W(AW)) wbi ();

    rv32_wb_interconnect #(
        .NUM_SLAVES(NS), .ADR_W(AW), .WIN_W(WW),
        .PERIPH_BASE(32'h8000_0000), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .mem_we_i(mem_we), .mem_re_i(mem_re), .mem_addr_i(mem_addr),
        .mem_data_i(mem_wdata), .mem_data_o(mem_rdata),
        .mem_stall_o(mem_stall), .mem_err_o(mem_err),
        .wb(wbi)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // expected outputs for the current cycle
    bit          exp_on = 1'b0;
    logic        exp_stall, exp_stb, exp_err, exp_we;
    logic [3:0]  exp_cyc, exp_sel;
    logic [31:0] exp_data, exp_wdat;
    logic [15:0] exp_adr;
    logic [31:0] m_data = 32'h0;   // model of the last returned data

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("stall", 32'(mem_stall), 32'(exp_stall));
            chk("cyc",   32'(wbi.slv_cyc_o), 32'(exp_cyc));
            chk("stb",   32'(wbi.wb_stb_o), 32'(exp_stb));
            chk("err",   32'(mem_err), 32'(exp_err));
            chk("rdata", mem_rdata, exp_data);
            if (exp_stb) begin
                chk("adr",  32'(wbi.wb_adr_o), 32'(exp_adr));
                chk("wdat", wbi.wb_dat_o, exp_wdat);
                chk("we",   32'(wbi.wb_we_o), 32'(exp_we));
                chk("sel",  32'(wbi.wb_sel_o), 32'(exp_sel));
            end
        end
    end

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_cyc = '0; exp_stb = 1'b0;
        exp_err = 1'b0;   exp_data = m_data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cyc"},   32'(wbi.slv_cyc_o), 0);
        chk({tag, "_stb"},   32'(wbi.wb_stb_o), 0);
        chk({tag, "_stall"}, 32'(mem_stall), 0);
        chk({tag, "_err"},   32'(mem_err), 0);
        chk({tag, "_data"},  mem_rdata, 0);
        chk({tag, "_adr"},   32'(wbi.wb_adr_o), 0);
        chk({tag, "_wdat"},  wbi.wb_dat_o, 0);
        chk({tag, "_we"},    32'(wbi.wb_we_o), 0);
        chk({tag, "_sel"},   32'(wbi.wb_sel_o), 0);
    endtask

    // One core access. lat = BUS cycle in which the target acks.
    // rst_at > 0 pulses reset in that BUS cycle instead of completing.
    task automatic xact(
        input  logic [31:0] addr, input logic [3:0] we, input logic re,
        input  logic [31:0] wd, input int lat, input bit spur,
        input  int rst_at, input bit fen, input logic [31:0] fdat,
        output int stalls, output logic [31:0] rdata, output logic err_seen,
        output logic [3:0] ocyc, output logic [3:0] osel,
        output logic [15:0] oadr, output logic owe
    );
        logic                  hit, req, is_wr, to_err;
        int                    idx, bus_len;
        logic [3:0]            oh;
        logic [NS-1:0][31:0]   sd;
        hit    = (addr[31:16] == 16'h8000);
        req    = hit && ((we != 4'h0) || re);
        is_wr  = (we != 4'h0);
        idx    = int'(addr[WW +: 4]);
        oh     = (idx < NS) ? (4'b0001 << idx) : 4'b0000;
        stalls = 0; ocyc = '0; osel = '0; oadr = '0; owe = 1'b0;
        err_seen = 1'b0;
        for (int s = 0; s < NS; s++) sd[s] = $urandom;
        if (fen && idx < NS) sd[idx] = fdat;

        // cycle 0: request presented
        @(posedge clk); #1;
        mem_addr = addr; mem_we = we; mem_re = re; mem_wdata = wd;
        wbi.slv_ack_i = '0; wbi.slv_dat_i = sd;
        set_idle_exp();
        exp_stall = req;
        @(negedge clk);
        stalls += int'(mem_stall); ocyc |= wbi.slv_cyc_o;
        rdata = mem_rdata;

        if (req) begin
            to_err = 1'b0;
            if (idx < NS) begin
                bus_len = lat;
`ifdef WB_TIMEOUT_EN
                if (lat > TO) begin bus_len = TO; to_err = 1'b1; end
`endif
                for (int c = 1; c <= bus_len; c++) begin
                    @(posedge clk); #1;
                    if (c == rst_at) begin
                        exp_on = 1'b0;
                        rst_n = 1'b0; mem_we = '0; mem_re = 1'b0; wbi.slv_ack_i = '0;
                        #1;
                        chk_all_zero("midbus_rst");
                        m_data = 32'h0;
                        @(negedge clk); rst_n = 1'b1;
                        @(posedge clk); #1;
                        set_idle_exp(); exp_on = 1'b1;
                        @(negedge clk);
                        return;
                    end
                    wbi.slv_ack_i = (c == lat) ? oh : 4'b0000;
                    if (spur) wbi.slv_ack_i |= 4'($urandom) & ~oh;
                    exp_stall = 1'b1; exp_cyc = oh; exp_stb = 1'b1;
                    exp_err = 1'b0;   exp_data = m_data;
                    exp_adr = addr[15:0]; exp_wdat = wd; exp_we = is_wr;
                    exp_sel = is_wr ? we : 4'hF;
                    @(negedge clk);
                    stalls += int'(mem_stall); ocyc |= wbi.slv_cyc_o;
                    if (wbi.wb_stb_o) begin
                        osel = wbi.wb_sel_o; oadr = wbi.wb_adr_o; owe = wbi.wb_we_o;
                    end
                end
                if (to_err)      m_data = 32'h0;
                else if (!is_wr) m_data = sd[idx];
            end else begin
                to_err = 1'b1;   // unmapped index
                m_data = 32'h0;
            end
            // response cycle, request still held
            @(posedge clk); #1;
            wbi.slv_ack_i = '0;
            set_idle_exp();
            exp_err = to_err;
            @(negedge clk);
            stalls += int'(mem_stall); ocyc |= wbi.slv_cyc_o;
            rdata = mem_rdata; err_seen = mem_err;
        end

        // idle cycle
        @(posedge clk); #1;
        mem_we = '0; mem_re = 1'b0; wbi.slv_ack_i = '0;
        set_idle_exp();
        @(negedge clk);
    endtask

    int          st;
    logic [31:0] rd;
    logic        er, owe;
    logic [3:0]  ocyc, osel;
    logic [15:0] oadr;

    initial begin
        rst_n = 1'b0;
        mem_we = '0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0;
        wbi.slv_ack_i = '0; wbi.slv_dat_i = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        set_idle_exp();
        exp_on = 1'b1;

        // zero-wait read from slave 2
        xact(32'h8000_2000, 4'h0, 1'b1, 32'h0, 1, 1'b0, 0, 1'b1, 32'hCAFE_F00D,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("rd2_data", rd, 32'hCAFE_F00D);
        chk("rd2_err", 32'(er), 0);
        chk("rd2_stalls", st, 2);
        chk("rd2_cyc", 32'(ocyc), 32'h4);
        chk("rd2_sel", 32'(osel), 32'hF);

        // byte write, ack after 5 wait cycles
        xact(32'h8000_1004, 4'b0010, 1'b0, 32'h0000_AB00, 6, 1'b0, 0, 1'b0, 32'h0,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("wr_stalls", st, 7);
        chk("wr_sel", 32'(osel), 32'h2);
        chk("wr_adr", 32'(oadr), 32'h1004);
        chk("wr_we", 32'(owe), 1);
        chk("wr_data_kept", rd, 32'hCAFE_F00D);

        // unmapped index 7
        xact(32'h8000_7010, 4'h0, 1'b1, 32'h0, 1, 1'b0, 0, 1'b0, 32'h0,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("unmap_cyc", 32'(ocyc), 0);
        chk("unmap_err", 32'(er), 1);
        chk("unmap_data", rd, 0);
        chk("unmap_stalls", st, 1);

        // unselected-slave acks ignored
        xact(32'h8000_0040, 4'h0, 1'b1, 32'h0, 5, 1'b1, 0, 1'b1, 32'h5A5A_0001,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("spur_data", rd, 32'h5A5A_0001);
        chk("spur_stalls", st, 6);

        // non-peripheral address is ignored
        xact(32'h0000_1000, 4'h0, 1'b1, 32'h0, 1, 1'b0, 0, 1'b0, 32'h0,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("nohit_stalls", st, 0);

`ifdef WB_TIMEOUT_EN
        // slave never acks: timeout after 8 BUS cycles
        xact(32'h8000_3000, 4'h0, 1'b1, 32'h0, 100, 1'b0, 0, 1'b0, 32'h0,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("to_err", 32'(er), 1);
        chk("to_data", rd, 0);
        chk("to_stalls", st, 9);
        // ack in the expiring cycle wins
        xact(32'h8000_3000, 4'h0, 1'b1, 32'h0, 8, 1'b0, 0, 1'b1, 32'h0BAD_C0DE,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("to_ack_err", 32'(er), 0);
        chk("to_ack_data", rd, 32'h0BAD_C0DE);
`endif

        // reset pulsed in the 2nd BUS cycle, then a clean read
        xact(32'h8000_1000, 4'h0, 1'b1, 32'h0, 50, 1'b0, 2, 1'b0, 32'h0,
             st, rd, er, ocyc, osel, oadr, owe);
        xact(32'h8000_3008, 4'h0, 1'b1, 32'h0, 2, 1'b0, 0, 1'b1, 32'h1234_5678,
             st, rd, er, ocyc, osel, oadr, owe);
        chk("post_rst_data", rd, 32'h1234_5678);
        chk("post_rst_stalls", st, 3);

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [3:0]  w;
            logic        r;
            if ($urandom_range(0, 99) < 88) a[31:16] = 16'h8000;
            else                             a[31:16] = 16'($urandom_range(0, 16'h7FFF));
            a[15:12] = 4'($urandom_range(0, 7));
            a[11:0]  = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin w = 4'($urandom_range(1, 15)); r = 1'b0; end
            else begin w = 4'h0; r = 1'b1; end
            if ($urandom_range(0, 9) == 0) begin w = 4'h0; r = 1'b0; end
            xact(a, w, r, $urandom, $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                 0, 1'b0, 32'h0, st, rd, er, ocyc, osel, oadr, owe);
        end

        exp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
